// File: rtl/pc_ras_unit_if.sv
// Fetch-side bundle of the PC/RAS unit: control, branch and target inputs
// toward the unit (slave), and PC, link and RAS status back to fetch (master).
interface pc_ras_unit_if #(
  parameter int XLEN = 32
);
  logic            stay;
  logic [2:0]      branch_type;
  logic            alu_zero;
  logic            alu_neg;
  logic [XLEN-1:0] pc_with_offset;
  logic [XLEN-1:0] target_pc;
  logic            is_call;
  logic            is_ret;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] return_pc;
  logic            taken;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_underflow;

  modport master (
    output stay, branch_type, alu_zero, alu_neg, pc_with_offset, target_pc,
           is_call, is_ret,
    input  pc, return_pc, taken, ras_top, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stay, branch_type, alu_zero, alu_neg, pc_with_offset, target_pc,
           is_call, is_ret,
    output pc, return_pc, taken, ras_top, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Fetch-stage PC register with next-PC select and a circular return-address
// stack; the RAS is built only when PCCALC_RAS_EN is defined.
module pc_ras_unit #(
  parameter int              XLEN      = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic         clk,
  input  logic         rst,
  pc_ras_unit_if.slave bus
);
  localparam logic [2:0] JMP_JAL  = 3'd1;
  localparam logic [2:0] JMP_JALR = 3'd2;
  localparam logic [2:0] JMP_BEQ  = 3'd3;
  localparam logic [2:0] JMP_BNE  = 3'd4;
  localparam logic [2:0] JMP_BLT  = 3'd5;
  localparam logic [2:0] JMP_BGT  = 3'd6;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            is_jal;
  logic            is_jalr;
  logic            taken;

  assign is_jal   = (bus.branch_type == JMP_JAL);
  assign is_jalr  = (bus.branch_type == JMP_JALR);
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    taken = 1'b0;
    case (bus.branch_type)
      JMP_JAL, JMP_JALR: taken = 1'b1;
      JMP_BEQ:           taken = bus.alu_zero;
      JMP_BNE:           taken = !bus.alu_zero;
      JMP_BLT:           taken = bus.alu_neg;
      JMP_BGT:           taken = !bus.alu_neg;
      default:           taken = 1'b0;
    endcase
  end

  // stay outranks every redirect; a stalled branch is dropped, not queued
  always_comb begin
    next_pc = pc_plus4;
    if (bus.stay)              next_pc = pc_q;
    else if (taken && is_jalr) next_pc = {bus.target_pc[XLEN-1:1], 1'b0};
    else if (taken)            next_pc = bus.pc_with_offset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= next_pc;
  end

  assign bus.pc        = pc_q;
  assign bus.return_pc = pc_plus4;
  assign bus.taken     = taken;

`ifdef PCCALC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   tp;
  logic [PW:0]     cnt;
  logic            underflow_q;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_idx;

  assign push   = !bus.stay && (is_jal || is_jalr) && bus.is_call;
  assign pop    = !bus.stay && is_jalr && bus.is_ret;
  // a coroutine swap overwrites the current top instead of advancing
  assign wr_idx = pop ? tp : tp + PW'(1);

  // Entries are not reset; cnt alone decides what is readable.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_mem[wr_idx] <= pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp          <= '0;
      cnt         <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      if (push && !pop) begin
        tp <= tp + PW'(1);
        if (cnt != DEPTH_C) cnt <= cnt + (PW+1)'(1);
      end else if (pop && !push) begin
        if (cnt != '0) begin
          tp  <= tp - PW'(1);
          cnt <= cnt - (PW+1)'(1);
        end else begin
          underflow_q <= 1'b1;
        end
      end else if (push && pop && cnt == '0) begin
        cnt <= (PW+1)'(1);
      end
    end
  end

  assign bus.ras_top       = (cnt != '0) ? ras_mem[tp] : '0;
  assign bus.ras_empty     = (cnt == '0);
  assign bus.ras_full      = (cnt == DEPTH_C);
  assign bus.ras_underflow = underflow_q;
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ^{bus.is_call, bus.is_ret};

  assign bus.ras_top       = '0;
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_full      = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: reset, sequential fetch, branch decode,
// stall, RAS overflow/underflow/coroutine, async reset and PC wrap.
module tb_pc_ras_unit;
`ifdef PCCALC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam logic [2:0] NONE = 3'd0, JAL = 3'd1, JALR = 3'd2, BEQ = 3'd3,
                         BNE = 3'd4, BLT = 3'd5, BGT = 3'd6, RSVD = 3'd7;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pc_ras_unit_if #(.XLEN(32)) bus ();

  pc_ras_unit #(.XLEN(32), .RAS_DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] bt, input logic z, input logic n,
                       input logic [31:0] pwo, input logic [31:0] tpc,
                       input logic call, input logic ret);
    bus.branch_type    = bt;
    bus.alu_zero       = z;
    bus.alu_neg        = n;
    bus.pc_with_offset = pwo;
    bus.target_pc      = tpc;
    bus.is_call        = call;
    bus.is_ret         = ret;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RAS-dependent expectations collapse to the constant outputs when disabled
  function automatic logic [31:0] rv(input logic [31:0] v, input logic [31:0] off);
    return RAS_EN ? v : off;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.stay = 1'b0;
    drive(NONE, 0, 0, 32'h0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", bus.pc, 32'h100);
    check("reset_empty", 32'(bus.ras_empty), 32'd1);
    check("reset_full", 32'(bus.ras_full), 32'd0);
    check("reset_uflow", 32'(bus.ras_underflow), 32'd0);
    check("reset_top", bus.ras_top, 32'h0);

    rst = 1'b0;
    #1;
    check("ret_pc_0", bus.return_pc, 32'h104);
    check("taken_none", 32'(bus.taken), 32'd0);
    tick; check("seq_1", bus.pc, 32'h104);
    tick; check("seq_2", bus.pc, 32'h108);
    tick; check("seq_3", bus.pc, 32'h10C);
    check("ret_pc_3", bus.return_pc, 32'h110);

    drive(JAL, 0, 0, 32'hC, 32'hAD, 0, 0); #1;
    check("jal_taken", 32'(bus.taken), 32'd1);
    tick; check("jal_pc", bus.pc, 32'hC);
    drive(BEQ, 1, 0, 32'hC, 32'hAD, 0, 0); #1;
    check("beq_taken", 32'(bus.taken), 32'd1);
    bus.pc_with_offset = 32'h20;
    tick; check("beq_pc", bus.pc, 32'h20);
    drive(BNE, 1, 0, 32'hC, 32'hAD, 0, 0); #1;
    check("bne_taken", 32'(bus.taken), 32'd0);
    tick; check("bne_pc", bus.pc, 32'h24);
    drive(BLT, 0, 1, 32'hC, 32'hAD, 0, 0); #1;
    check("blt_taken", 32'(bus.taken), 32'd1);
    tick; check("blt_pc", bus.pc, 32'hC);
    drive(BGT, 0, 1, 32'hC, 32'hAD, 0, 0); #1;
    check("bgt_taken", 32'(bus.taken), 32'd0);
    tick; check("bgt_pc", bus.pc, 32'h10);
    drive(BGT, 0, 0, 32'hC, 32'hAD, 0, 0); #1;
    check("bgt_ge_taken", 32'(bus.taken), 32'd1);
    drive(RSVD, 1, 1, 32'hC, 32'hAD, 0, 0); #1;
    check("rsvd_taken", 32'(bus.taken), 32'd0);
    drive(JALR, 0, 0, 32'hC, 32'hAD, 0, 0);
    tick; check("jalr_pc", bus.pc, 32'hAC);

    bus.stay = 1'b1;
    drive(JAL, 0, 0, 32'h40, 32'h0, 1, 0);
    tick;
    check("stall_pc", bus.pc, 32'hAC);
    check("stall_empty", 32'(bus.ras_empty), 32'd1);
    bus.stay = 1'b0;
    tick;
    check("unstall_pc", bus.pc, 32'h40);
    check("unstall_top", bus.ras_top, rv(32'hB0, 32'h0));

    drive(JAL, 0, 0, 32'h0, 32'h0, 0, 0);
    tick; check("to_zero", bus.pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(JAL, 0, 0, 32'(i + 1) * 32'h10, 32'h0, 1, 0);
      tick;
    end
    check("calls_pc", bus.pc, 32'h50);
    check("ovf_full", 32'(bus.ras_full), rv(32'd1, 32'd0));
    check("ovf_top", bus.ras_top, rv(32'h44, 32'h0));
    check("ovf_empty", 32'(bus.ras_empty), rv(32'd0, 32'd1));

    drive(JALR, 0, 0, 32'h0, 32'h61, 0, 1);
    tick; check("pop1_top", bus.ras_top, rv(32'h34, 32'h0));
    check("pop1_pc", bus.pc, 32'h60);
    check("pop1_full", 32'(bus.ras_full), 32'd0);
    bus.target_pc = 32'h71;
    tick; check("pop2_top", bus.ras_top, rv(32'h24, 32'h0));
    bus.target_pc = 32'h81;
    tick; check("pop3_top", bus.ras_top, rv(32'h14, 32'h0));
    bus.target_pc = 32'h91;
    tick; check("pop4_empty", 32'(bus.ras_empty), 32'd1);
    check("pop4_top", bus.ras_top, 32'h0);
    check("pop4_uflow", 32'(bus.ras_underflow), 32'd0);

    bus.target_pc = 32'hA0;
    tick;
    check("uflow_pulse", 32'(bus.ras_underflow), rv(32'd1, 32'd0));
    check("uflow_empty", 32'(bus.ras_empty), 32'd1);
    check("uflow_pc", bus.pc, 32'hA0);
    drive(NONE, 0, 0, 32'h0, 32'h0, 0, 0);
    tick;
    check("uflow_clear", 32'(bus.ras_underflow), 32'd0);
    check("uflow_seq_pc", bus.pc, 32'hA4);

    drive(JAL, 0, 0, 32'hB0, 32'h0, 1, 0); tick;
    drive(JAL, 0, 0, 32'h80, 32'h0, 1, 0); tick;
    check("cnt2_top", bus.ras_top, rv(32'hB4, 32'h0));
    drive(JALR, 0, 0, 32'h0, 32'hC0, 1, 1); tick;
    check("coro_pc", bus.pc, 32'hC0);
    check("coro_top", bus.ras_top, rv(32'h84, 32'h0));
    drive(JALR, 0, 0, 32'h0, 32'hD0, 0, 1); tick;
    check("coro_pop1_top", bus.ras_top, rv(32'hA8, 32'h0));
    check("coro_pop1_empty", 32'(bus.ras_empty), rv(32'd0, 32'd1));
    bus.target_pc = 32'hE0; tick;
    check("coro_pop2_empty", 32'(bus.ras_empty), 32'd1);
    drive(JALR, 0, 0, 32'h0, 32'hF0, 1, 1); tick;
    check("coro_empty_top", bus.ras_top, rv(32'hE4, 32'h0));
    check("coro_empty_uflow", 32'(bus.ras_underflow), 32'd0);
    check("coro_empty_pc", bus.pc, 32'hF0);

    drive(JAL, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0); tick;
    check("wrap_pre_pc", bus.pc, 32'hFFFF_FFFC);
    drive(NONE, 0, 0, 32'h0, 32'h0, 0, 0); #1;
    check("wrap_ret_pc", bus.return_pc, 32'h0);
    tick; check("wrap_pc", bus.pc, 32'h0);

    drive(JAL, 0, 0, 32'h200, 32'h0, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", bus.pc, 32'h100);
    check("async_rst_empty", 32'(bus.ras_empty), 32'd1);
    tick;
    check("rst_hold_pc", bus.pc, 32'h100);
    check("rst_hold_top", bus.ras_top, 32'h0);
    rst = 1'b0;
    drive(NONE, 0, 0, 32'h0, 32'h0, 0, 0);
    tick;
    check("post_rst_pc", bus.pc, 32'h104);
    check("post_rst_empty", 32'(bus.ras_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
